button_repeater_array: RTL

Parametrised, multi-channel button conditioner: per-channel input synchronisation, tick-based debouncing, and hold-to-repeat with optional acceleration. It is the next generation of the single-button repeater and sits between the raw board buttons and any UI/menu logic. It runs entirely in the system clock domain using a shared tick prescaler, with no derived clock. Each channel provides a level output and a single-cycle event output.

---
 rtl/button_repeater_array_pkg.sv | 18 +
 rtl/button_repeater_array_channel.sv | 194 +++++++++++++++++++
 rtl/button_repeater_array.sv | 66 ++++++
 3 files changed

// File: rtl/button_repeater_array_pkg.sv
// Shared types and helpers for the multi-channel button conditioner:
// FSM state encoding and the counter width helper.
package button_repeater_array_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_repeater_array_channel.sv
// One button lane: 2-flop synchroniser, tick-based debouncer, hold/repeat FSM
// with period acceleration, and registered level/pulse outputs.
module button_repeater_array_channel
    import button_repeater_array_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 8,
    parameter int MIN_PERIOD     = 2,
    parameter int ACCEL_AFTER    = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_tick,
    input  logic i_button,
    input  logic i_repeat_en,
    output logic o_button,
    output logic o_pulse
);

    localparam int ACCEL_LAST_I = (ACCEL_AFTER > 0) ? (ACCEL_AFTER - 1) : 0;
    localparam int DW = width_of(DEBOUNCE_TICKS - 1);
    localparam int WW = width_of(REPEAT_DELAY - 1);
    localparam int PW = width_of(REPEAT_PERIOD);
    localparam int RW = width_of(ACCEL_LAST_I);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(REPEAT_DELAY - 1);
    localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
    localparam logic [PW-1:0] PER_INIT   = PW'(REPEAT_PERIOD);
    localparam logic [PW-1:0] PER_MIN    = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] PER_ONE    = PW'(1);
    localparam logic [RW-1:0] ACCEL_LAST = RW'(ACCEL_LAST_I);
    localparam logic [RW-1:0] REP_ONE    = RW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          clean_q, clean_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] period_q, period_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          button_q, button_d;
    logic          pulse_q, pulse_d;
    logic [PW-1:0] period_half;

    // Synchroniser shift and debouncer: a change is accepted after DEBOUNCE_TICKS differing ticks.
    always_comb begin
        sync1_d   = i_button;
        sync2_d   = sync1_q;
        clean_d   = clean_q;
        deb_cnt_d = deb_cnt_q;
        if (i_tick) begin
            if (sync2_q != clean_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    clean_d   = sync2_q;
                    deb_cnt_d = {DW{1'b0}};
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end else begin
                deb_cnt_d = {DW{1'b0}};
            end
        end else begin
            deb_cnt_d = deb_cnt_q;
        end
    end

    // Hold/repeat FSM; reacts to the debouncer update in the same cycle, falls take priority.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        phase_d     = phase_q;
        period_d    = period_q;
        rep_cnt_d   = rep_cnt_q;
        pulse_d     = 1'b0;
        period_half = {1'b0, period_q[PW-1:1]};
        case (state_q)
            S_IDLE: begin
                if (clean_d) begin
                    state_d    = S_HOLD;
                    pulse_d    = 1'b1;
                    wait_cnt_d = {WW{1'b0}};
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!clean_d) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = {WW{1'b0}};
                end else if (i_tick) begin
                    if (i_repeat_en && (wait_cnt_q == WAIT_LAST)) begin
                        state_d   = S_REPEAT;
                        pulse_d   = 1'b1;
                        period_d  = PER_INIT;
                        phase_d   = {PW{1'b0}};
                        rep_cnt_d = {RW{1'b0}};
                    end else if (wait_cnt_q != WAIT_LAST) begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_REPEAT: begin
                if (!clean_d) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = {WW{1'b0}};
                    phase_d    = {PW{1'b0}};
                    period_d   = {PW{1'b0}};
                    rep_cnt_d  = {RW{1'b0}};
                end else if (!i_repeat_en) begin
                    state_d    = S_HOLD;
                    wait_cnt_d = WAIT_LAST;
                    phase_d    = {PW{1'b0}};
                    rep_cnt_d  = {RW{1'b0}};
                end else if (i_tick) begin
                    if (phase_q == (period_q - PER_ONE)) begin
                        pulse_d = 1'b1;
                        phase_d = {PW{1'b0}};
                        if ((ACCEL_AFTER != 0) && (rep_cnt_q == ACCEL_LAST)) begin
                            period_d  = (period_half < PER_MIN) ? PER_MIN : period_half;
                            rep_cnt_d = {RW{1'b0}};
                        end else if (ACCEL_AFTER != 0) begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end else begin
                            rep_cnt_d = rep_cnt_q;
                        end
                    end else begin
                        phase_d = phase_q + PER_ONE;
                    end
                end else begin
                    state_d = S_REPEAT;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = {WW{1'b0}};
                phase_d    = {PW{1'b0}};
                period_d   = {PW{1'b0}};
                rep_cnt_d  = {RW{1'b0}};
            end
        endcase
    end

    // Output level decoded from the next state so it is registered alongside it.
    always_comb begin
        case (state_d)
            S_IDLE:   button_d = 1'b0;
            S_HOLD:   button_d = 1'b1;
            S_REPEAT: button_d = (phase_d < {1'b0, period_d[PW-1:1]});
            default:  button_d = 1'b0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            clean_q    <= 1'b0;
            deb_cnt_q  <= {DW{1'b0}};
            state_q    <= S_IDLE;
            wait_cnt_q <= {WW{1'b0}};
            phase_q    <= {PW{1'b0}};
            period_q   <= {PW{1'b0}};
            rep_cnt_q  <= {RW{1'b0}};
            button_q   <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            clean_q    <= clean_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            phase_q    <= phase_d;
            period_q   <= period_d;
            rep_cnt_q  <= rep_cnt_d;
            button_q   <= button_d;
            pulse_q    <= pulse_d;
        end
    end

    assign o_button = button_q;
    assign o_pulse  = pulse_q;

endmodule

// File: rtl/button_repeater_array.sv
// Multi-channel button conditioner: one shared tick prescaler feeding an
// array of independent debounce/hold-to-repeat channels.
module button_repeater_array
    import button_repeater_array_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int TICK_DIV       = 32768,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 8,
    parameter int MIN_PERIOD     = 2,
    parameter int ACCEL_AFTER    = 4
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_buttons,
    input  logic [CHANNELS-1:0] i_repeat_en,
    output logic [CHANNELS-1:0] o_buttons,
    output logic [CHANNELS-1:0] o_pulses
);

    localparam int TW = width_of(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    // Prescaler: tick is high on the last count, then the counter wraps.
    always_comb begin
        tick = (tick_cnt_q == TICK_LAST);
        if (tick) begin
            tick_cnt_d = {TW{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            tick_cnt_q <= {TW{1'b0}};
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_repeater_array_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .MIN_PERIOD     (MIN_PERIOD),
            .ACCEL_AFTER    (ACCEL_AFTER)
        ) u_channel (
            .i_clock     (i_clock),
            .i_reset_n   (i_reset_n),
            .i_tick      (tick),
            .i_button    (i_buttons[g]),
            .i_repeat_en (i_repeat_en[g]),
            .o_button    (o_buttons[g]),
            .o_pulse     (o_pulses[g])
        );
    end

endmodule
